// File: rtl/dpram_rr_arbiter.sv
`timescale 1ns/1ps
// dpram_rr_arbiter
// Round-robin arbiter sharing a dual-port RAM (ports A/B, read-before-write,
// 1-cycle registered read) among NREQ requesters. Each cycle it grants up to
// two requests, one per RAM port. It never grants two requests to the same
// address when either of them writes. Read data is routed back to the
// requester that issued the read.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   req_valid/we/addr/wdata per-requester request (packed, requester i at slice i)
//   req_ready               grant; transfer occurs when valid & ready
//   rsp_valid/rsp_data      per-requester read response (data slices hold when idle)
//   ram_we/addr/din_{a,b}   RAM port drive
//   ram_q_{a,b}             RAM registered read data
//
// Optional feature (macro ARB_STATS_EN): adds saturating 16-bit outputs
//   conflict_cnt (cycles with a valid requester skipped on an address conflict)
//   grant_cnt    (number of transfers)
module dpram_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_data,
`ifdef ARB_STATS_EN
  output logic [15:0]        conflict_cnt,
  output logic [15:0]        grant_cnt,
`endif
  output logic               ram_we_a,
  output logic               ram_we_b,
  output logic [AW-1:0]      ram_addr_a,
  output logic [AW-1:0]      ram_addr_b,
  output logic [DW-1:0]      ram_din_a,
  output logic [DW-1:0]      ram_din_b,
  input  logic [DW-1:0]      ram_q_a,
  input  logic [DW-1:0]      ram_q_b
);

  localparam int unsigned PW = $clog2(NREQ);
  typedef logic [PW-1:0] idx_t;

  logic [AW-1:0] addr_arr  [NREQ];
  logic [DW-1:0] wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*AW +: AW];
    assign wdata_arr[g] = req_wdata[g*DW +: DW];
  end

  idx_t ptr_q, ptr_d;
  logic scan_a_vld, scan_b_vld;
  idx_t scan_a_idx, scan_b_idx;
  logic gnt_a, gnt_b;
`ifdef ARB_STATS_EN
  logic conflict_skip;
`endif

  // Pipeline stage: one entry per RAM port, tracking who is owed read data.
  logic pa_vld_q, pa_rd_q, pb_vld_q, pb_rd_q;
  idx_t pa_idx_q, pb_idx_q;
  logic [NREQ*DW-1:0] hold_q;

  // Scan from ptr: first valid takes port A, the next non-conflicting valid
  // takes port B. Conflicting candidates are skipped, not blocking the scan.
  always_comb begin : arb
    logic [PW:0] sum;
    idx_t        idx;
    sum        = '0;
    idx        = '0;
    scan_a_vld = 1'b0;
    scan_b_vld = 1'b0;
    scan_a_idx = '0;
    scan_b_idx = '0;
`ifdef ARB_STATS_EN
    conflict_skip = 1'b0;
`endif
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (req_valid[idx]) begin
        if (!scan_a_vld) begin
          scan_a_vld = 1'b1;
          scan_a_idx = idx;
        end else if (!scan_b_vld) begin
          if ((addr_arr[idx] == addr_arr[scan_a_idx]) &&
              (req_we[idx] || req_we[scan_a_idx])) begin
`ifdef ARB_STATS_EN
            conflict_skip = 1'b1;
`endif
          end else begin
            scan_b_vld = 1'b1;
            scan_b_idx = idx;
          end
        end
      end
    end
  end

  // Grants are forced off while reset is asserted.
  assign gnt_a = scan_a_vld & rst_n;
  assign gnt_b = scan_b_vld & rst_n;

  always_comb begin
    req_ready = '0;
    if (gnt_a) req_ready[scan_a_idx] = 1'b1;
    if (gnt_b) req_ready[scan_b_idx] = 1'b1;
  end

  always_comb begin
    ram_we_a   = gnt_a & req_we[scan_a_idx];
    ram_addr_a = gnt_a ? addr_arr[scan_a_idx]  : '0;
    ram_din_a  = gnt_a ? wdata_arr[scan_a_idx] : '0;
    ram_we_b   = gnt_b & req_we[scan_b_idx];
    ram_addr_b = gnt_b ? addr_arr[scan_b_idx]  : '0;
    ram_din_b  = gnt_b ? wdata_arr[scan_b_idx] : '0;
  end

  // Pointer moves past the last granted requester; B is always scanned after A.
  always_comb begin : ptr_next
    idx_t last;
    last  = gnt_b ? scan_b_idx : scan_a_idx;
    ptr_d = ptr_q;
    if (gnt_a) ptr_d = (last == idx_t'(NREQ - 1)) ? '0 : last + idx_t'(1);
  end

  // Responses come purely from registered state; idle slices replay hold_q.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = hold_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pa_vld_q && pa_rd_q && (pa_idx_q == idx_t'(i))) begin
        rsp_valid[i]           = 1'b1;
        rsp_data[i*DW +: DW]   = ram_q_a;
      end else if (pb_vld_q && pb_rd_q && (pb_idx_q == idx_t'(i))) begin
        rsp_valid[i]           = 1'b1;
        rsp_data[i*DW +: DW]   = ram_q_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      pa_vld_q <= 1'b0;
      pa_rd_q  <= 1'b0;
      pa_idx_q <= '0;
      pb_vld_q <= 1'b0;
      pb_rd_q  <= 1'b0;
      pb_idx_q <= '0;
      hold_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      pa_vld_q <= gnt_a;
      pa_rd_q  <= ~req_we[scan_a_idx];
      pa_idx_q <= scan_a_idx;
      pb_vld_q <= gnt_b;
      pb_rd_q  <= ~req_we[scan_b_idx];
      pb_idx_q <= scan_b_idx;
      hold_q   <= rsp_data;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] conflict_cnt_q, grant_cnt_q;
  logic [16:0] grant_sum;

  assign grant_sum = {1'b0, grant_cnt_q} + 17'(gnt_a) + 17'(gnt_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
      grant_cnt_q    <= '0;
    end else begin
      if (conflict_skip && (conflict_cnt_q != 16'hFFFF)) begin
        conflict_cnt_q <= conflict_cnt_q + 16'd1;
      end
      grant_cnt_q <= grant_sum[16] ? 16'hFFFF : grant_sum[15:0];
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign grant_cnt    = grant_cnt_q;
`endif

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for dpram_rr_arbiter with a behavioural 8x32 dual-port RAM.
module tb_dpram_rr_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid, req_we, req_ready, rsp_valid;
  logic [11:0]  req_addr;
  logic [127:0] req_wdata, rsp_data;
  logic         ram_we_a, ram_we_b;
  logic [2:0]   ram_addr_a, ram_addr_b;
  logic [31:0]  ram_din_a, ram_din_b, ram_q_a, ram_q_b;
`ifdef ARB_STATS_EN
  logic [15:0]  conflict_cnt, grant_cnt;
`endif

  dpram_rr_arbiter #(.NREQ(4), .AW(3), .DW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
`ifdef ARB_STATS_EN
    .conflict_cnt(conflict_cnt),
    .grant_cnt  (grant_cnt),
`endif
    .ram_we_a   (ram_we_a),
    .ram_we_b   (ram_we_b),
    .ram_addr_a (ram_addr_a),
    .ram_addr_b (ram_addr_b),
    .ram_din_a  (ram_din_a),
    .ram_din_b  (ram_din_b),
    .ram_q_a    (ram_q_a),
    .ram_q_b    (ram_q_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: read-before-write, registered read.
  logic [31:0] mem [8];
  always @(posedge clk) begin
    ram_q_a <= mem[ram_addr_a];
    ram_q_b <= mem[ram_addr_b];
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every asserted rsp_valid bit must match the oldest expected read.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (rsp_valid[i]) begin
          if (sbq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_rsp: requester %0d rsp_valid got 1 expected 0", i);
          end else begin
            e = sbq.pop_front();
            chk("rsp_idx", 128'(i), 128'(e.idx));
            chk("rsp_data", rsp_data[i*32 +: 32], e.data);
            chk("rsp_latency", 128'(cyc), 128'(e.cyc + 1));
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input bit v, input bit we, input logic [2:0] a,
                         input logic [31:0] d);
    req_valid[i]          = v;
    req_we[i]             = we;
    req_addr[i*3 +: 3]    = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  // Called 1ns after a rising edge: checks grants, queues expected reads.
  task automatic step(input string name, input logic [3:0] exp_rdy,
                      input logic [127:0] exp_d, input bit push);
    #2;
    chk(name, 128'(req_ready), 128'(exp_rdy));
    if (push) begin
      for (int i = 0; i < 4; i++) begin
        if (exp_rdy[i] && !req_we[i]) sbq.push_back('{i, exp_d[i*32 +: 32], cyc});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_we    = 4'hF;
    #2;
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_ram_we", 128'({ram_we_a, ram_we_b}), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_data", rsp_data, 128'(0));
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  localparam logic [31:0] M0 = 32'hA0A0_0000;
  localparam logic [31:0] M1 = 32'hA1A1_0001;
  localparam logic [31:0] M2 = 32'hA2A2_0002;
  localparam logic [31:0] M6 = 32'hA6A6_0006;
  localparam logic [31:0] M7 = 32'hA7A7_0007;

  initial begin
    mem[0] = M0;
    mem[1] = M1;
    mem[2] = M2;
    mem[3] = 32'hDEAD_BEEF;
    mem[4] = 32'hA4A4_0004;
    mem[5] = 32'hA5A5_0005;
    mem[6] = M6;
    mem[7] = M7;
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Single read, one-cycle latency, data slice holds afterwards.
    do_reset();
    set_req(0, 1, 0, 3'd3, 32'h0);
    step("t1_grant", 4'b0001, {96'h0, 32'hDEAD_BEEF}, 1'b1);
    set_req(0, 0, 0, 3'd0, 32'h0);
    step("t1_idle", 4'b0000, 128'h0, 1'b0);
    #2;
    chk("t1_rsp_clear", 128'(rsp_valid), 128'(0));
    chk("t1_hold", 128'(rsp_data[31:0]), 128'(32'hDEAD_BEEF));
    @(posedge clk);
    #1;

    // Write/read conflict on addr 5: read waits one cycle and sees new data.
    do_reset();
    set_req(1, 1, 1, 3'd5, 32'h1234_5678);
    set_req(2, 1, 0, 3'd5, 32'h0);
    step("t2_c0", 4'b0010, 128'h0, 1'b1);
    set_req(1, 0, 0, 3'd0, 32'h0);
    step("t2_c1", 4'b0100, {32'h0, 32'h1234_5678, 64'h0}, 1'b1);
    set_req(2, 0, 0, 3'd0, 32'h0);
    step("t2_idle", 4'b0000, 128'h0, 1'b0);
`ifdef ARB_STATS_EN
    chk("t2_conflict_cnt", 128'(conflict_cnt), 128'(1));
    chk("t2_grant_cnt", 128'(grant_cnt), 128'(2));
`endif

    // Skip-and-continue: req1 conflicts with req0's write, req2 takes port B.
    do_reset();
    set_req(0, 1, 1, 3'd4, 32'hCAFE_F00D);
    set_req(1, 1, 0, 3'd4, 32'h0);
    set_req(2, 1, 0, 3'd6, 32'h0);
    step("t3_c0", 4'b0101, {32'h0, M6, 64'h0}, 1'b1);
    set_req(0, 0, 0, 3'd0, 32'h0);
    set_req(2, 0, 0, 3'd0, 32'h0);
    step("t3_c1", 4'b0010, {64'h0, 32'hCAFE_F00D, 32'h0}, 1'b1);
    set_req(1, 0, 0, 3'd0, 32'h0);
    step("t3_idle", 4'b0000, 128'h0, 1'b0);

    // Four continuous readers: grants alternate {0,1}, {2,3}.
    do_reset();
    set_req(0, 1, 0, 3'd0, 32'h0);
    set_req(1, 1, 0, 3'd1, 32'h0);
    set_req(2, 1, 0, 3'd6, 32'h0);
    set_req(3, 1, 0, 3'd7, 32'h0);
    for (int r = 0; r < 2; r++) begin
      step("t4_pair01", 4'b0011, {M7, M6, M1, M0}, 1'b1);
      step("t4_pair23", 4'b1100, {M7, M6, M1, M0}, 1'b1);
    end
    req_valid = '0;
    step("t4_idle", 4'b0000, 128'h0, 1'b0);

    // Two reads of the same address are both granted.
    set_req(0, 1, 0, 3'd2, 32'h0);
    set_req(3, 1, 0, 3'd2, 32'h0);
    step("t5_same_addr", 4'b1001, {M2, 64'h0, M2}, 1'b1);
    req_valid = '0;
    step("t5_idle", 4'b0000, 128'h0, 1'b0);

    // Reset pulse between a read grant and its response edge.
    set_req(2, 1, 0, 3'd6, 32'h0);
    #2;
    chk("t6_grant", 128'(req_ready), 128'(4'b0100));
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_ready_in_reset", 128'(req_ready), 128'(0));
    #2;
    req_valid = '0;
    rst_n     = 1'b1;
    @(posedge clk);
    #3;
    chk("t6_no_rsp", 128'(rsp_valid), 128'(0));
    @(posedge clk);
    #1;
    // Pointer restarted at 0: {0,1} rather than {3,0}.
    set_req(0, 1, 0, 3'd0, 32'h0);
    set_req(1, 1, 0, 3'd1, 32'h0);
    set_req(3, 1, 0, 3'd7, 32'h0);
    step("t6_ptr0", 4'b0011, {M7, 32'h0, M1, M0}, 1'b1);
    set_req(0, 0, 0, 3'd0, 32'h0);
    set_req(1, 0, 0, 3'd0, 32'h0);
    step("t6_next", 4'b1000, {M7, 96'h0}, 1'b1);
    req_valid = '0;
    step("t6_idle", 4'b0000, 128'h0, 1'b0);

`ifdef ARB_STATS_EN
    // Two writers to one address conflict every cycle; counters saturate.
    do_reset();
    set_req(1, 1, 1, 3'd5, 32'h1111_1111);
    set_req(2, 1, 1, 3'd5, 32'h2222_2222);
    repeat (70000) @(posedge clk);
    #1;
    req_valid = '0;
    step("t7_idle", 4'b0000, 128'h0, 1'b0);
    chk("t7_conflict_sat", 128'(conflict_cnt), 128'(16'hFFFF));
    chk("t7_grant_sat", 128'(grant_cnt), 128'(16'hFFFF));
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 128'(sbq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dpram_rr_arbiter.md
Name: dpram_rr_arbiter

Overview:
- Round-robin arbiter that shares the 8x32 dual-port RAM (ports A/B, read-before-write, 1-cycle registered read) among NREQ requesters.
- Each cycle it grants up to two requests, one per RAM port.
- It suppresses same-address write collisions between the two ports.
- It routes registered read data back to the requester that issued the read.
- Sits between client engines and the RAM macro; the RAM's clock is this block's clk.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 3, RAM address width
- DW, 32, RAM data width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request pending, per requester
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data
- req_ready  out  NREQ  grant; transfer occurs when valid & ready
- rsp_valid  out  NREQ  read data valid, per requester
- rsp_data  out  NREQ*DW  packed read data
- ram_we_a, ram_we_b  out  1  RAM write enables
- ram_addr_a, ram_addr_b  out  AW  RAM addresses
- ram_din_a, ram_din_b  out  DW  RAM write data
- ram_q_a, ram_q_b  in  DW  RAM registered read data

Behaviour:
- State: rr pointer ptr [clog2(NREQ)], plus a response pipeline stage.
  - Pipeline stage holds: per-port valid bit, requester index, and read flag.
- Grant logic is combinational from req_* and ptr.
  - Scan indices ptr, ptr+1, ... mod NREQ.
  - First valid requester gets port A.
  - Scanning continues for port B; the next valid requester is granted unless it conflicts with A.
  - Conflict: addr equal and either side writes.
  - A conflicting candidate is skipped and scanning continues.
  - Two reads to the same address do not conflict; both are granted.
- req_ready[i] = 1 only for the granted indices; at most 2 bits set.
- req_ready does not depend on any requester's ready history; a requester may hold valid and wait indefinitely.
- RAM drive:
  - Granted port: addr and din taken from the granted requester; ram_we = that requester's we.
  - Ungranted port: ram_we = 0, addr = 0, din = 0.
- ptr update on any grant: ptr <= (index of last granted requester + 1) mod NREQ. No grant: ptr holds.
- Reads:
  - Granted in cycle N → rsp_valid[i] = 1 in cycle N+1, for one cycle.
  - rsp_data slice i = ram_q of the port used.
  - Other slices of rsp_data hold their last value.
- Writes produce no rsp_valid; a write is complete at the granting clock edge.
- Same requester cannot hold both ports in one cycle.
- Reset (rst_n low, async):
  - ptr = 0, pipeline valid = 0, rsp_valid = 0, rsp_data = 0.
  - req_ready = 0 and ram_we_a/b = 0, forced combinationally while rst_n is low.
- Reset mid-operation:
  - An in-flight read response is dropped; no rsp_valid after release.
  - A RAM write presented at the same edge that reset asserts is not guaranteed.
- First cycle after reset release: arbitration starts from index 0.
- rsp_valid uses only registered state; it never asserts in the same cycle as the grant.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt [15:0].
  - Increments once per cycle in which at least one valid requester was skipped due to an address conflict.
  - Saturates at 16'hFFFF; reset to 0.
  - Adds output grant_cnt [15:0], counting transfers (+1 or +2 per cycle), saturating.
- Undefined: the outputs and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then req0 read addr 3 (RAM[3] preloaded 0xDEADBEEF):
  - req_ready[0] = 1 at cycle N.
  - rsp_valid[0] = 1 and rsp_data[0] = 0xDEADBEEF at N+1; rsp_valid = 0 at N+2.
- req1 write addr 5 data 0x12345678 and req2 read addr 5, same cycle (ptr = 0):
  - Only req1 granted; req2 granted next cycle.
  - req2 reads 0x12345678.
  - With ARB_STATS_EN, conflict_cnt = 1.
- All 4 requesters reading distinct addresses continuously, ptr = 0:
  - Grants in pairs {0,1}, {2,3}, {0,1}, ...
  - Each response returns to the correct requester with the correct data.
- req0 and req3 both read addr 2:
  - Both granted the same cycle.
  - Both rsp_data slices equal RAM[2] at N+1.
- req2 read granted, rst_n pulsed low before the next edge:
  - rsp_valid stays 0; ptr = 0; req_ready = 0 during reset.
- With ARB_STATS_EN, force 70000 conflicting cycles:
  - conflict_cnt saturates at 0xFFFF and does not wrap.
